// File: rtl/sam_mem_pkg.sv
// Shared types and defaults for the SAM/CPU single-port RAM arbiter.
package sam_mem_pkg;

  localparam int unsigned MEM_WORDS_DEF = 16384;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_SAM  = 2'd2
  } owner_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

endpackage

// File: rtl/sam_mem_range_chk.sv
// Maps a byte address to a RAM word index and flags addresses past the end of RAM.
module sam_mem_range_chk
  import sam_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
  parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
  input  logic [31:0]   addr,
  output logic          in_range,
  output logic [AW-1:0] word_idx
);

  logic [29:0] idx_full;
  logic        unused_bits;

  assign idx_full    = addr[31:2];
  assign in_range    = 32'(idx_full) < 32'(MEM_WORDS);
  assign word_idx    = idx_full[AW-1:0];
  assign unused_bits = ^addr[1:0];

endmodule

// File: rtl/sam_mem_arbiter.sv
// Single-port RAM shared by a SAM engine (absolute priority, no backpressure)
// and a picorv32-style CPU bus; also tracks out-of-range accesses and CPU stalls.
module sam_mem_arbiter
  import sam_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         cpu_mem_valid,
  input  logic [31:0]                  cpu_mem_addr,
  input  logic [31:0]                  cpu_mem_wdata,
  input  logic [3:0]                   cpu_mem_wstrb,
  output logic                         cpu_mem_ready,
  output logic [31:0]                  cpu_mem_rdata,
  input  logic                         mem_en_SAM,
  input  logic [31:0]                  mem_addr_SAM,
  input  logic [31:0]                  mem_wdata_SAM,
  input  logic [3:0]                   mem_wstrb_SAM,
  output logic [31:0]                  mem_rdata_SAM,
  output logic                         ram_en,
  output logic [3:0]                   ram_we,
  output logic [$clog2(MEM_WORDS)-1:0] ram_addr,
  output logic [31:0]                  ram_wdata,
  input  logic [31:0]                  ram_rdata,
  output logic                         err,
  output logic [31:0]                  err_addr,
  input  logic                         err_clr,
  output logic [CNT_W-1:0]             cpu_stall_cnt
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  state_e         state_q, state_d;
  owner_e         owner_q, owner_d;
  logic           oor_q, oor_d;
  mem_req_t       cpu_req, sam_req;
  logic           cpu_in, sam_in;
  logic [AW-1:0]  cpu_idx, sam_idx;
  logic           cpu_gnt, sam_gnt;
  logic           sam_oor, cpu_oor, new_err;
  logic [31:0]    new_addr;
  logic           stall_inc;

  assign cpu_req = '{addr: cpu_mem_addr, wdata: cpu_mem_wdata, wstrb: cpu_mem_wstrb};
  assign sam_req = '{addr: mem_addr_SAM, wdata: mem_wdata_SAM, wstrb: mem_wstrb_SAM};

  sam_mem_range_chk #(.MEM_WORDS(MEM_WORDS), .AW(AW)) u_cpu_chk (
    .addr     (cpu_req.addr),
    .in_range (cpu_in),
    .word_idx (cpu_idx)
  );

  sam_mem_range_chk #(.MEM_WORDS(MEM_WORDS), .AW(AW)) u_sam_chk (
    .addr     (sam_req.addr),
    .in_range (sam_in),
    .word_idx (sam_idx)
  );

  // SAM wins every cycle it pulses; CPU only gets the port from IDLE.
  assign sam_gnt = mem_en_SAM;
  assign cpu_gnt = !mem_en_SAM && cpu_mem_valid && (state_q == ST_IDLE);

  // RAM port mux; out-of-range grants complete without touching the RAM.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 4'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (Rst) begin
      if (sam_gnt) begin
        ram_en    = sam_in;
        ram_we    = sam_in ? sam_req.wstrb : 4'b0;
        ram_addr  = sam_idx;
        ram_wdata = sam_req.wdata;
      end else if (cpu_gnt) begin
        ram_en    = cpu_in;
        ram_we    = cpu_in ? cpu_req.wstrb : 4'b0;
        ram_addr  = cpu_idx;
        ram_wdata = cpu_req.wdata;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cpu_gnt) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_mem_ready = 1'b0;
    cpu_mem_rdata = '0;
    if (state_q == ST_RESP) begin
      cpu_mem_ready = 1'b1;
      if ((owner_q == OWN_CPU) && !oor_q) cpu_mem_rdata = ram_rdata;
    end
  end

  // Owner tag steers next cycle's ram_rdata to whoever issued the read.
  always_comb begin
    owner_d = OWN_NONE;
    oor_d   = 1'b0;
    if (sam_gnt && (sam_req.wstrb == 4'b0)) begin
      owner_d = OWN_SAM;
      oor_d   = !sam_in;
    end else if (cpu_gnt && (cpu_req.wstrb == 4'b0)) begin
      owner_d = OWN_CPU;
      oor_d   = !cpu_in;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      owner_q <= OWN_NONE;
      oor_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      oor_q   <= oor_d;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                    mem_rdata_SAM <= '0;
    else if (owner_q == OWN_SAM) mem_rdata_SAM <= oor_q ? 32'h0 : ram_rdata;
  end

  assign sam_oor  = sam_gnt && !sam_in;
  assign cpu_oor  = cpu_gnt && !cpu_in;
  assign new_err  = sam_oor || cpu_oor;
  assign new_addr = sam_oor ? sam_req.addr : cpu_req.addr;

  // First error is sticky; a fresh error in the clear cycle re-arms with its address.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (new_err && (err_clr || !err)) begin
      err      <= 1'b1;
      err_addr <= new_addr;
    end else if (err_clr) begin
      err      <= 1'b0;
      err_addr <= '0;
    end
  end

  assign stall_inc = cpu_mem_valid && (state_q == ST_IDLE) && mem_en_SAM;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) cpu_stall_cnt <= '0;
    else if (stall_inc && (cpu_stall_cnt != {CNT_W{1'b1}}))
      cpu_stall_cnt <= cpu_stall_cnt + CNT_W'(1);
  end

endmodule
